demux_18_collector: RTL and testbench
=====================================

// Module: demux_18_collector
// PURPOSE
//  Receive side of the 8:1 mux scan path: a registered 1-to-8 demultiplexer.
//  Steers a stream of WIDTH-bit samples into 8 channel slots, either by
//  explicit select or by an auto-incrementing slot counter, and assembles
//  them into one 8-slot frame. Presents each complete frame on a
//  valid/ready output, then clears its slots for the next frame.
// PARAMETERS
//  WIDTH    1   bits per channel sample
//  TIMEOUT  16  idle cycles in COLLECT before a partial frame is dropped (>=2)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active high
//  in_valid   in   1        sample offered
//  in_ready   out  1        sample accepted when in_valid & in_ready
//  in_data    in   WIDTH    sample value
//  select     in   3        target slot (addressed mode only)
//  mode       in   1        0 = addressed (use select), 1 = sequential (counter)
//  out        out  8*WIDTH  frame; slot k at out[k*WIDTH +: WIDTH]
//  out_valid  out  1        frame available
//  out_ready  in   1        frame consumed when out_valid & out_ready
//  err        out  1        one-cycle pulse on duplicate slot write or timeout
// BEHAVIOUR
//  - Clock is clk; reset is rst, synchronous, active high. While rst is high
//    at a clk edge: state=IDLE, out=0, out_valid=0, err=0, fill mask=0,
//    slot counter=0, idle counter=0. in_ready=0 while rst is asserted.
//  - FSM states: IDLE, COLLECT, HOLD. in_ready=1 in IDLE and COLLECT.
//  - IDLE: on accept, latch frame mode from mode, write slot, go COLLECT.
//    The frame mode is frozen until the frame ends; mode changes mid-frame
//    are ignored.
//  - Slot choice: addressed mode uses select. Sequential mode uses the slot
//    counter: 0 on the first beat, +1 per accept, so slot 7 is the 8th beat.
//  - Accept writes in_data to the chosen slot of out and sets its fill bit.
//  - Addressed duplicate (fill bit already set): overwrite the slot and
//    pulse err for one cycle. The frame still needs 8 distinct slots.
//  - Completion: the accept that makes the fill mask 8'hFF moves to HOLD.
//    out_valid=1 on the next cycle, so latency = 1 clk from the last accept.
//    out is stable while out_valid=1.
//  - HOLD: out_valid=1 until out_ready. On the handshake: out_valid=0, fill
//    mask=0, slot counter=0, go IDLE. out keeps the old data until the
//    slots are overwritten.
//  - Timeout: the idle counter counts COLLECT cycles with no accept and
//    resets on each accept. On reaching TIMEOUT: clear fill mask and slot
//    counter, pulse err, go IDLE. out_valid is never raised for a partial
//    frame.
//  - Same-cycle duplicate and timeout: timeout wins, one err pulse.
//  - rst mid-frame or in HOLD: the frame is discarded and all reset values
//    apply on the next cycle.
// CONFIGURATION
//  DEMUX_18_SKID_EN
//   defined: in HOLD, in_ready=out_ready. A sample accepted on the release
//    cycle is the first beat of the next frame, with IDLE rules applied
//    (mode latched, slot 0 in sequential). Back-to-back frames have no
//    bubble.
//   undefined: in_ready=0 in HOLD. At least one idle cycle between frames.
// TESTING
//  1. Sequential: mode=1, 8 beats in_data=1,0,1,0,1,0,1,0 on consecutive
//     cycles -> out=8'h55 and out_valid=1 one clk after beat 8; err=0.
//  2. Addressed: selects 7,6,5,4,3,2,1,0 with data 1,1,1,1,0,0,0,0 ->
//     out=8'hF0 and out_valid=1. Hold out_ready=0 for 5 cycles -> out
//     stable, in_ready=0 (macro off).
//  3. Duplicate: addressed, select=3 twice (data 0 then 1), then the other
//     7 slots with 0 -> err pulses once on the second write; final out=8'h08.
//  4. Timeout: 3 sequential beats, then in_valid=0 for 16 cycles -> err pulse,
//     out_valid stays 0. The next 8 beats start at slot 0.
//  5. Reset mid-frame: 5 beats, then rst=1 for one cycle -> out=0, out_valid=0,
//     fill cleared. A following full frame completes normally.
//  6. Skid (macro on): out_ready=1 with in_valid held high -> frames every
//     8 cycles with no bubble, and the release-cycle beat lands in slot 0.
//     Macro off -> 9-cycle cadence.

Source files
------------

// File: rtl/demux_18_collector.sv
// rtl/demux_18_collector.sv - registered 1-to-8 sample demux assembling 8-slot frames
// Optional: DEMUX_18_SKID_EN lets the release cycle of HOLD accept the next frame's first beat.
module demux_18_collector #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         select,
  input  logic               mode,
  output logic [8*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam int         CW        = $clog2(TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic [8*WIDTH-1:0] out_q, out_d;
  logic [7:0]         fill_q, fill_d;
  logic [2:0]         slot_q, slot_d;
  logic [CW-1:0]      idle_q, idle_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;

  logic       accept;
  logic       fresh;
  logic       frame_mode;
  logic [2:0] slot_idx;
  logic [7:0] slot_bit;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE, S_COLLECT: in_ready = 1'b1;
        S_HOLD: begin
`ifdef DEMUX_18_SKID_EN
          in_ready = out_ready;
`else
          in_ready = 1'b0;
`endif
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Any beat accepted outside COLLECT opens a new frame: mode is sampled live, counter starts at 0.
  always_comb begin
    accept     = in_valid & in_ready;
    fresh      = (state_q != S_COLLECT);
    frame_mode = fresh ? mode : mode_q;
    slot_idx   = frame_mode ? (fresh ? 3'd0 : slot_q) : select;
    slot_bit   = 8'd1 << slot_idx;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    fill_d  = fill_q;
    slot_d  = slot_q;
    idle_d  = idle_q;
    mode_d  = mode_q;
    err_d   = 1'b0;

    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (slot_idx == k[2:0]) out_d[k*WIDTH +: WIDTH] = in_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = mode;
          fill_d  = slot_bit;
          slot_d  = slot_idx + 3'd1;
          idle_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          fill_d = fill_q | slot_bit;
          err_d  = |(fill_q & slot_bit);
          slot_d = slot_idx + 3'd1;
          idle_d = '0;
          if ((fill_q | slot_bit) == 8'hFF) state_d = S_HOLD;
        end else if (idle_q == CW'(TIMEOUT - 1)) begin
          // Partial frame is dropped; out keeps stale slot data but is never validated.
          fill_d  = 8'd0;
          slot_d  = 3'd0;
          idle_d  = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          fill_d  = 8'd0;
          slot_d  = 3'd0;
          idle_d  = '0;
          state_d = S_IDLE;
          if (accept) begin
            mode_d  = mode;
            fill_d  = slot_bit;
            slot_d  = slot_idx + 3'd1;
            state_d = S_COLLECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      fill_q  <= 8'd0;
      slot_q  <= 3'd0;
      idle_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fill_q  <= fill_d;
      slot_q  <= slot_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == S_HOLD);
  assign err       = err_q;

endmodule

// File: tb/tb_demux_18_collector.sv
// tb/tb_demux_18_collector.sv - scoreboard bench for demux_18_collector
// Honours DEMUX_18_SKID_EN for HOLD in_ready and frame cadence expectations.
module tb_demux_18_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:0] in_data = 1'b0;
  logic [2:0] select = 3'd0;
  logic       mode = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err;

  int n_cmp = 0;
  int n_mis = 0;
  int err_cnt = 0;
  logic [7:0] sb[$];

  demux_18_collector #(.WIDTH(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .select(select), .mode(mode), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cnt++;

  task automatic beat(input logic [2:0] sel, input logic d, input logic m);
    in_valid = 1'b1;
    select   = sel;
    in_data  = d;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic complete_frame(input string name);
    int waited = 0;
    logic [7:0] exp;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL %s: out_valid=%b after %0d cycles, required 1", name, out_valid, waited);
    end else begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL %s: frame out=%h arrived, required none queued", name, out);
      end else begin
        exp = sb.pop_front();
        if (out !== exp) begin
          n_mis++;
          $display("FAIL %s: out=%h required %h", name, out, exp);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_release: out_valid=%b required 0", name, out_valid);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out, out_valid, err, in_ready} !== 11'd0) begin
      n_mis++;
      $display("FAIL reset: out=%h ov=%b err=%b ir=%b required all 0", out, out_valid, err, in_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] d = 8'h55;
    int e0 = err_cnt;
    sb.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin
      beat(3'd0, d[i], 1'b1);
      if (i == 6) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_mis++;
          $display("FAIL seq_early: out_valid=%b after 7 beats, required 0", out_valid);
        end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL seq_latency: out_valid=%b one clk after beat 8, required 1", out_valid);
    end
    complete_frame("seq");
    n_cmp++;
    if (err_cnt != e0) begin
      n_mis++;
      $display("FAIL seq_err: err pulses=%0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_addressed();
    logic [7:0] d = 8'hF0;
    sb.push_back(8'hF0);
    for (int i = 7; i >= 0; i--) beat(3'(i), d[i], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out !== 8'hF0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL addr_hold%0d: out=%h ov=%b ir=%b required F0 1 0", c, out, out_valid, in_ready);
      end
    end
    complete_frame("addr");
  endtask

  task automatic test_duplicate();
    int e0 = err_cnt;
    sb.push_back(8'h08);
    beat(3'd3, 1'b0, 1'b0);
    beat(3'd3, 1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++;
      $display("FAIL dup_pulse: err=%b after duplicate write, required 1", err);
    end
    for (int i = 0; i < 8; i++) if (i != 3) beat(3'(i), 1'b0, 1'b0);
    complete_frame("dup");
    n_cmp++;
    if (err_cnt - e0 != 1) begin
      n_mis++;
      $display("FAIL dup_count: err pulses=%0d required 1", err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    int saw_valid = 0;
    logic [7:0] d = 8'h86;
    for (int i = 0; i < 3; i++) beat(3'd0, 1'b1, 1'b1);
    for (int c = 0; c < 18; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) saw_valid++;
    end
    n_cmp++;
    if (err_cnt - e0 != 1 || saw_valid != 0) begin
      n_mis++;
      $display("FAIL timeout: err pulses=%0d valid cycles=%0d required 1 0", err_cnt - e0, saw_valid);
    end
    sb.push_back(8'h86);
    for (int i = 0; i < 8; i++) beat(3'd0, d[i], 1'b1);
    complete_frame("after_timeout");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'hA3;
    for (int i = 0; i < 5; i++) beat(3'd0, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_mid: out=%h ov=%b ir=%b required 00 0 0", out, out_valid, in_ready);
    end
    rst = 1'b0;
    sb.push_back(8'hA3);
    for (int i = 0; i < 8; i++) beat(3'd0, d[i], 1'b1);
    complete_frame("after_rst");
  endtask

  task automatic test_back_to_back();
    logic [63:0] stream = {$urandom, $urandom};
    logic [7:0] frame = 8'h00;
    logic [7:0] exp;
    int n = 0;
    int nslot = 0;
    int frames = 0;
    int last_hs = -1;
    int e0 = err_cnt;
`ifdef DEMUX_18_SKID_EN
    int cadence = 8;
`else
    int cadence = 9;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = 1'b1;
    for (int cyc = 0; cyc < 100 && frames < 4; cyc++) begin
      in_data = stream[n];
      @(negedge clk);
      if (out_valid === 1'b1) begin
        frames++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("FAIL b2b_frame%0d: out=%h required none queued", frames, out);
        end else begin
          exp = sb.pop_front();
          if (out !== exp) begin
            n_mis++;
            $display("FAIL b2b_frame%0d: out=%h required %h", frames, out, exp);
          end
        end
        if (last_hs >= 0) begin
          n_cmp++;
          if (cyc - last_hs != cadence) begin
            n_mis++;
            $display("FAIL b2b_cadence: interval=%0d required %0d", cyc - last_hs, cadence);
          end
        end
        last_hs = cyc;
      end
      if (in_ready === 1'b1) begin
        frame[nslot] = stream[n];
        n++;
        nslot++;
        if (nslot == 8) begin
          sb.push_back(frame);
          nslot = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (frames != 4 || err_cnt != e0) begin
      n_mis++;
      $display("FAIL b2b_total: frames=%0d err pulses=%0d required 4 0", frames, err_cnt - e0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_addressed();
    test_duplicate();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
